// File: rtl/delay_scheduler_pkg.sv
// Shared encodings and defaults for the delay scheduler timing blocks.
package delay_scheduler_pkg;

  localparam int unsigned W_DEFAULT = 28;
  localparam int unsigned NREQ      = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    COUNT = 3'b010,
    DONE  = 3'b100
  } state_e;

  // Requester index to its one-hot grant/done bit.
  function automatic logic [NREQ-1:0] onehot2(input logic idx);
    onehot2 = idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/delay_scheduler_if.sv
// Request/grant bundle between requesters (master) and the scheduler (slave).
interface delay_scheduler_if #(
  parameter int unsigned W = delay_scheduler_pkg::W_DEFAULT
) ();

  logic [1:0]   req;
  logic [W-1:0] delay0;
  logic [W-1:0] delay1;
  logic [1:0]   grant;
  logic [1:0]   done;
  logic         busy;

  modport master (output req, delay0, delay1, input grant, done, busy);
  modport slave  (input req, delay0, delay1, output grant, done, busy);

endinterface

// File: rtl/delay_scheduler_counter.sv
// Loadable W-bit down counter that saturates at 1; updates on the falling clock edge.
module down_counter #(
  parameter int unsigned W = delay_scheduler_pkg::W_DEFAULT
) (
  input  logic         clk100Mhz,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         is_one
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (enable && (count_q > W'(1))) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(negedge clk100Mhz or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign is_one = (count_q == W'(1));

endmodule

// File: rtl/delay_scheduler.sv
// Two-requester round-robin scheduler sharing one delay counter; done pulses after the granted delay.
module delay_scheduler
  import delay_scheduler_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input logic               clk100Mhz,
  input logic               reset,
  delay_scheduler_if.slave  bus
);

  state_e     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] done_q, done_d;
  logic       busy_q, busy_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;

  logic         pick;
  logic [W-1:0] sel_delay;
  logic         cnt_load;
  logic         cnt_enable;
  logic [W-1:0] cnt_value;
  logic [W-1:0] cnt_count;
  logic         cnt_is_one;

  down_counter #(.W(W)) u_counter (
    .clk100Mhz (clk100Mhz),
    .reset     (reset),
    .load      (cnt_load),
    .value     (cnt_value),
    .enable    (cnt_enable),
    .count     (cnt_count),
    .is_one    (cnt_is_one)
  );

  // Arbitration, counter control and next-state.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    done_d     = 2'b00;
    owner_d    = owner_q;
    last_d     = last_q;
    cnt_load   = 1'b0;
    cnt_enable = 1'b0;
    pick       = (bus.req == 2'b11) ? ~last_q : bus.req[1];
    sel_delay  = pick ? bus.delay1 : bus.delay0;
    cnt_value  = (sel_delay == '0) ? W'(1) : sel_delay;

    case (state_q)
      IDLE: begin
        if (bus.req != 2'b00) begin
          state_d  = COUNT;
          owner_d  = pick;
          grant_d  = onehot2(pick);
          cnt_load = 1'b1;
        end
      end
      COUNT: begin
        if (!bus.req[owner_q]) begin
          state_d = IDLE;
          grant_d = 2'b00;
          last_d  = owner_q;
        end else if (cnt_is_one) begin
          state_d = DONE;
          grant_d = 2'b00;
          done_d  = onehot2(owner_q);
          last_d  = owner_q;
        end else begin
          cnt_enable = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(negedge clk100Mhz or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      done_q  <= 2'b00;
      busy_q  <= 1'b0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;

  // A loaded counter is never zero while an operation is in flight.
  a_count_nonzero: assert property (@(negedge clk100Mhz) disable iff (reset)
    (state_q == COUNT) |-> (cnt_count != '0));

endmodule

// File: tb/tb_delay_scheduler.sv
// Scoreboard bench for delay_scheduler: grant order, done latency, abort and reset behaviour.
module tb_delay_scheduler;
  import delay_scheduler_pkg::*;

  localparam int unsigned W = W_DEFAULT;

  typedef struct packed {
    logic [1:0] grant;
    int         lat;
  } exp_t;

  logic clk100Mhz;
  logic reset;
  int   checks;
  int   failures;
  int   cyc;
  exp_t sb_q[$];

  delay_scheduler_if #(.W(W)) bus ();

  delay_scheduler #(.W(W)) dut (
    .clk100Mhz (clk100Mhz),
    .reset     (reset),
    .bus       (bus)
  );

  initial clk100Mhz = 1'b0;
  always #5 clk100Mhz = ~clk100Mhz;

  initial cyc = 0;
  always @(negedge clk100Mhz) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input logic [1:0] g, input int lat);
    exp_t e;
    e.grant = g;
    e.lat   = lat;
    sb_q.push_back(e);
  endtask

  task automatic wait_grant(output logic [1:0] g, output int at, output bit tmo);
    tmo = 1'b1; g = 2'b00; at = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk100Mhz);
      if (bus.grant != 2'b00) begin
        g = bus.grant; at = cyc; tmo = 1'b0;
        break;
      end
    end
  endtask

  task automatic wait_done(output logic [1:0] d, output int at, output bit tmo);
    tmo = 1'b1; d = 2'b00; at = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk100Mhz);
      if (bus.done != 2'b00) begin
        d = bus.done; at = cyc; tmo = 1'b0;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk100Mhz);
    reset   = 1'b1;
    bus.req = 2'b00;
    repeat (2) @(posedge clk100Mhz);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req = 2'b00; bus.delay0 = '0; bus.delay1 = '0;
    repeat (3) @(posedge clk100Mhz);
    checks++; if (bus.grant !== 2'b00) begin failures++; $display("FAIL reset_grant: got %b expected 00", bus.grant); end
    checks++; if (bus.done !== 2'b00) begin failures++; $display("FAIL reset_done: got %b expected 00", bus.done); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [1:0] g, d; int c0, gc, dc; bit tmo; exp_t e;
    @(posedge clk100Mhz);
    bus.delay0 = W'(5); bus.req = 2'b01; c0 = cyc;
    push_exp(2'b01, 5);
    wait_grant(g, gc, tmo);
    e = sb_q.pop_front();
    checks++; if (tmo || g !== e.grant) begin failures++; $display("FAIL single_grant: got %b expected %b timeout=%0d", g, e.grant, tmo); end
    checks++; if (gc != c0 + 1) begin failures++; $display("FAIL single_grant_edge: got cycle %0d expected %0d", gc, c0 + 1); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %b expected 1", bus.busy); end
    wait_done(d, dc, tmo);
    checks++; if (tmo || d !== e.grant) begin failures++; $display("FAIL single_done: got %b expected %b timeout=%0d", d, e.grant, tmo); end
    checks++; if (dc - gc != e.lat) begin failures++; $display("FAIL single_latency: got %0d expected %0d", dc - gc, e.lat); end
    bus.req = 2'b00;
    @(posedge clk100Mhz);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 2'b00) begin failures++; $display("FAIL single_after_done: busy=%b done=%b expected 0 00", bus.busy, bus.done); end
  endtask

  task automatic test_simultaneous();
    logic [1:0] g, d; int gc, dc; bit tmo; exp_t e;
    do_reset();
    @(posedge clk100Mhz);
    bus.delay0 = W'(3); bus.delay1 = W'(4); bus.req = 2'b11;
    push_exp(2'b01, 3);
    push_exp(2'b10, 4);
    wait_grant(g, gc, tmo);
    e = sb_q.pop_front();
    checks++; if (tmo || g !== e.grant) begin failures++; $display("FAIL sim_first_grant: got %b expected %b timeout=%0d", g, e.grant, tmo); end
    wait_done(d, dc, tmo);
    checks++; if (tmo || d !== e.grant || dc - gc != e.lat) begin failures++; $display("FAIL sim_first_done: got %b after %0d expected %b after %0d", d, dc - gc, e.grant, e.lat); end
    bus.req = 2'b10;
    wait_grant(g, gc, tmo);
    e = sb_q.pop_front();
    checks++; if (tmo || g !== e.grant) begin failures++; $display("FAIL sim_second_grant: got %b expected %b timeout=%0d", g, e.grant, tmo); end
    checks++; if (gc != dc + 2) begin failures++; $display("FAIL sim_second_grant_edge: got cycle %0d expected %0d", gc, dc + 2); end
    wait_done(d, dc, tmo);
    checks++; if (tmo || d !== e.grant || dc - gc != e.lat) begin failures++; $display("FAIL sim_second_done: got %b after %0d expected %b after %0d", d, dc - gc, e.grant, e.lat); end
    bus.req = 2'b00;
    @(posedge clk100Mhz);
  endtask

  task automatic test_zero_delay();
    logic [1:0] g, d; int gc, dc; bit tmo; exp_t e;
    @(posedge clk100Mhz);
    bus.delay1 = '0; bus.req = 2'b10;
    push_exp(2'b10, 1);
    wait_grant(g, gc, tmo);
    e = sb_q.pop_front();
    checks++; if (tmo || g !== e.grant) begin failures++; $display("FAIL zero_grant: got %b expected %b timeout=%0d", g, e.grant, tmo); end
    wait_done(d, dc, tmo);
    checks++; if (tmo || d !== e.grant || dc - gc != e.lat) begin failures++; $display("FAIL zero_done: got %b after %0d expected %b after %0d", d, dc - gc, e.grant, e.lat); end
    bus.req = 2'b00;
    @(posedge clk100Mhz);
  endtask

  task automatic test_delay_sampled();
    logic [1:0] g, d; int gc, dc; bit tmo; exp_t e;
    @(posedge clk100Mhz);
    bus.delay0 = W'(4); bus.req = 2'b01;
    push_exp(2'b01, 4);
    wait_grant(g, gc, tmo);
    e = sb_q.pop_front();
    bus.delay0 = W'(20);
    checks++; if (tmo || g !== e.grant) begin failures++; $display("FAIL sampled_grant: got %b expected %b timeout=%0d", g, e.grant, tmo); end
    wait_done(d, dc, tmo);
    checks++; if (tmo || d !== e.grant || dc - gc != e.lat) begin failures++; $display("FAIL sampled_done: got %b after %0d expected %b after %0d", d, dc - gc, e.grant, e.lat); end
    bus.req = 2'b00;
    @(posedge clk100Mhz);
  endtask

  task automatic test_abort();
    logic [1:0] g, d; int gc, gc2, dc; bit tmo; bit seen; exp_t e;
    @(posedge clk100Mhz);
    bus.delay0 = W'(10); bus.delay1 = W'(2); bus.req = 2'b01;
    push_exp(2'b01, 0);
    push_exp(2'b10, 2);
    wait_grant(g, gc, tmo);
    e = sb_q.pop_front();
    checks++; if (tmo || g !== e.grant) begin failures++; $display("FAIL abort_grant: got %b expected %b timeout=%0d", g, e.grant, tmo); end
    bus.req = 2'b11;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk100Mhz);
      if (bus.done != 2'b00) seen = 1'b1;
    end
    checks++; if (bus.grant !== 2'b01) begin failures++; $display("FAIL abort_hold_owner: got %b expected 01", bus.grant); end
    bus.req = 2'b10;
    @(posedge clk100Mhz);
    if (bus.done != 2'b00) seen = 1'b1;
    checks++; if (bus.grant !== 2'b00 || bus.busy !== 1'b0) begin failures++; $display("FAIL abort_clear: grant=%b busy=%b expected 00 0", bus.grant, bus.busy); end
    checks++; if (seen) begin failures++; $display("FAIL abort_no_done: got a done pulse expected none"); end
    wait_grant(g, gc2, tmo);
    e = sb_q.pop_front();
    checks++; if (tmo || g !== e.grant || gc2 != gc + 6) begin failures++; $display("FAIL abort_next_grant: got %b at %0d expected %b at %0d", g, gc2, e.grant, gc + 6); end
    wait_done(d, dc, tmo);
    checks++; if (tmo || d !== e.grant || dc - gc2 != e.lat) begin failures++; $display("FAIL abort_next_done: got %b after %0d expected %b after %0d", d, dc - gc2, e.grant, e.lat); end
    bus.req = 2'b00;
    @(posedge clk100Mhz);
  endtask

  task automatic test_reset_mid_count();
    logic [1:0] g; int gc; bit tmo; bit seen; exp_t e;
    @(posedge clk100Mhz);
    bus.delay0 = W'(8); bus.req = 2'b01;
    push_exp(2'b01, 0);
    wait_grant(g, gc, tmo);
    e = sb_q.pop_front();
    checks++; if (tmo || g !== e.grant) begin failures++; $display("FAIL rmid_grant: got %b expected %b timeout=%0d", g, e.grant, tmo); end
    repeat (5) @(posedge clk100Mhz);
    #1 reset = 1'b1;
    #1;
    checks++; if (bus.grant !== 2'b00 || bus.done !== 2'b00 || bus.busy !== 1'b0) begin failures++; $display("FAIL rmid_async: grant=%b done=%b busy=%b expected 00 00 0", bus.grant, bus.done, bus.busy); end
    bus.req = 2'b00;
    repeat (2) @(posedge clk100Mhz);
    reset = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk100Mhz);
      if (bus.done != 2'b00) seen = 1'b1;
    end
    checks++; if (seen) begin failures++; $display("FAIL rmid_no_done: got a done pulse expected none"); end
    bus.delay0 = W'(2); bus.delay1 = W'(2); bus.req = 2'b11;
    push_exp(2'b01, 0);
    wait_grant(g, gc, tmo);
    e = sb_q.pop_front();
    checks++; if (tmo || g !== e.grant) begin failures++; $display("FAIL rmid_priority: got %b expected %b timeout=%0d", g, e.grant, tmo); end
    bus.req = 2'b00;
    repeat (2) @(posedge clk100Mhz);
  endtask

  task automatic test_fairness();
    logic [1:0] g, d; int gc, dc; bit tmo; exp_t e;
    do_reset();
    @(posedge clk100Mhz);
    bus.delay0 = W'(2); bus.delay1 = W'(2); bus.req = 2'b11;
    for (int i = 0; i < 6; i++) push_exp((i % 2 == 0) ? 2'b01 : 2'b10, 2);
    for (int i = 0; i < 6; i++) begin
      wait_grant(g, gc, tmo);
      e = sb_q.pop_front();
      checks++; if (tmo || g !== e.grant) begin failures++; $display("FAIL fair_grant_%0d: got %b expected %b timeout=%0d", i, g, e.grant, tmo); end
      wait_done(d, dc, tmo);
      checks++; if (tmo || d !== e.grant || dc - gc != e.lat) begin failures++; $display("FAIL fair_done_%0d: got %b after %0d expected %b after %0d", i, d, dc - gc, e.grant, e.lat); end
    end
    bus.req = 2'b00;
    repeat (2) @(posedge clk100Mhz);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single();
    test_simultaneous();
    test_zero_delay();
    test_delay_sampled();
    test_abort();
    test_reset_mid_count();
    test_fairness();
    checks++; if (sb_q.size() != 0) begin failures++; $display("FAIL scoreboard_empty: got %0d entries expected 0", sb_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
